mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit (MDU) in the EX stage, beside the combinational ALU.
- Runs signed and unsigned multiply and divide, and owns the architectural HI/LO registers.
- Asserts a busy flag for a configurable latency so the hazard unit can stall later MDU instructions.
- Successor to the fixed-width single-cycle ALU: parametrised width and latency, sequential operation, and state held across instructions.

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation starts and parked in shadow
// registers; a down-counter holds Busy high for the operation's latency and
// HI/LO take the shadow values on the edge where the counter reaches zero.
// Optional build macro MDU_DIV0_FLAG_EN: a divide by zero does not commit and
// instead raises a one-cycle E_MDU_DivZero pulse after the final busy edge.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_MDU_A,
  input  logic [WIDTH-1:0] E_MDU_B,
  input  logic [2:0]       E_MDU_MDUOp,
  input  logic             E_MDU_Start,
  output logic             E_MDU_Busy,
  output logic [WIDTH-1:0] E_MDU_HI,
  output logic [WIDTH-1:0] E_MDU_LO
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             E_MDU_DivZero
`endif
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   shhi_q, shhi_d, shlo_q, shlo_d;
  logic [2*WIDTH-1:0] mul_res, div_res;
`ifdef MDU_DIV0_FLAG_EN
  logic               div0_q, div0_d;
  logic               dz_q, dz_d;
`endif

  // Full-width product; sign-extending to 2*WIDTH makes the truncated product
  // exact for both signed and unsigned operands.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic signed [2*WIDTH-1:0] ea, eb;
    ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes, then
  // the quotient takes the sign of A^B and the remainder the sign of A.
  // Divide-by-zero and the most-negative / -1 overflow are pinned explicitly.
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic [WIDTH-1:0] ma, mb, q, r;
    logic             neg_a, neg_b;
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ma    = neg_a ? (~a + 1'b1) : a;
    mb    = neg_b ? (~b + 1'b1) : b;
    if (b == '0) begin
      return {a, {WIDTH{1'b1}}};
    end
    if (sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}})) begin
      return {{WIDTH{1'b0}}, a};
    end
    q = ma / mb;
    r = ma % mb;
    return {(neg_a ? (~r + 1'b1) : r), ((neg_a ^ neg_b) ? (~q + 1'b1) : q)};
  endfunction

  assign mul_res = mul_full(E_MDU_A, E_MDU_B, E_MDU_MDUOp == OP_MULT);
  assign div_res = div_full(E_MDU_A, E_MDU_B, E_MDU_MDUOp == OP_DIV);

  // Next-state: count down while running and commit on the 1->0 step;
  // when idle, accept a start (a start while busy is ignored).
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    shhi_d = shhi_q;
    shlo_d = shlo_q;
`ifdef MDU_DIV0_FLAG_EN
    div0_d = div0_q;
    dz_d   = 1'b0;
`endif
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        if (div0_q) begin
          dz_d = 1'b1;
        end else begin
          hi_d = shhi_q;
          lo_d = shlo_q;
        end
`else
        hi_d = shhi_q;
        lo_d = shlo_q;
`endif
      end
    end else if (E_MDU_Start) begin
      case (E_MDU_MDUOp)
        OP_MULT, OP_MULTU: begin
          {shhi_d, shlo_d} = mul_res;
          cnt_d            = CNT_W'(MULT_CYCLES);
          busy_d           = 1'b1;
`ifdef MDU_DIV0_FLAG_EN
          div0_d           = 1'b0;
`endif
        end
        OP_DIV, OP_DIVU: begin
          {shhi_d, shlo_d} = div_res;
          cnt_d            = CNT_W'(DIV_CYCLES);
          busy_d           = 1'b1;
`ifdef MDU_DIV0_FLAG_EN
          div0_d           = (E_MDU_B == '0);
`endif
        end
        OP_MTHI: hi_d = E_MDU_A;
        OP_MTLO: lo_d = E_MDU_A;
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      shhi_q <= '0;
      shlo_q <= '0;
`ifdef MDU_DIV0_FLAG_EN
      div0_q <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      shhi_q <= shhi_d;
      shlo_q <= shlo_d;
`ifdef MDU_DIV0_FLAG_EN
      div0_q <= div0_d;
      dz_q   <= dz_d;
`endif
    end
  end

  assign E_MDU_Busy = busy_q;
  assign E_MDU_HI   = hi_q;
  assign E_MDU_LO   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
  assign E_MDU_DivZero = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/latency entries are
// queued when an operation is issued and compared when Busy falls.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int MC  = 5;
  localparam int DC  = 10;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] A, B;
  logic [2:0]   op;
  logic         start;
  logic         busy;
  logic [W-1:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
  logic         dz;
`endif

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .E_MDU_A     (A),
    .E_MDU_B     (B),
    .E_MDU_MDUOp (op),
    .E_MDU_Start (start),
    .E_MDU_Busy  (busy),
    .E_MDU_HI    (hi),
    .E_MDU_LO    (lo)
`ifdef MDU_DIV0_FLAG_EN
    ,
    .E_MDU_DivZero (dz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_hi, m_lo;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic using the simulator's native 64-bit integer types.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] rh, output logic [W-1:0] rl,
                       output int lat, output logic rdz);
    longint          ps;
    longint unsigned pu;
    int              q, r;
    rh = m_hi; rl = m_lo; rdz = 1'b0;
    lat = (o == OP_MULT || o == OP_MULTU) ? MC : DC;
    case (o)
      OP_MULT:  begin ps = longint'(int'(a)) * longint'(int'(b)); rh = ps[63:32]; rl = ps[31:0]; end
      OP_MULTU: begin pu = {32'b0, a} * {32'b0, b}; rh = pu[63:32]; rl = pu[31:0]; end
      default: begin
        if (b == 0) begin
`ifdef MDU_DIV0_FLAG_EN
          rdz = 1'b1;
`else
          rh = a; rl = 32'hFFFF_FFFF;
`endif
        end else if (o == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rh = 32'h0; rl = 32'h8000_0000;
        end else if (o == OP_DIV) begin
          q = int'(a) / int'(b); r = int'(a) % int'(b);
          rh = r; rl = q;
        end else begin
          rh = a % b; rl = a / b;
        end
      end
    endcase
  endtask

  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
  endtask

  task automatic push_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    model(o, a, b, e.hi, e.lo, e.lat, e.dz);
    sb.push_back(e);
    drive(o, a, b);
  endtask

  // Count busy cycles (optionally injecting an illegal start at busy cycle
  // inj), then pop the scoreboard and compare.
  task automatic wait_commit(input int inj);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin
      if (n == 0) begin
        check("hold_hi", {32'b0, hi}, {32'b0, m_hi});
        check("hold_lo", {32'b0, lo}, {32'b0, m_lo});
      end
      if (n == inj) begin
        op = OP_MULT; A = 5; B = 5; start = 1'b1;
      end
      n++;
      @(negedge clk);
      start = 1'b0; op = 3'b000;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(n), 64'(e.lat));
      check("hi", {32'b0, hi}, {32'b0, e.hi});
      check("lo", {32'b0, lo}, {32'b0, e.lo});
`ifdef MDU_DIV0_FLAG_EN
      check("divzero", {63'b0, dz}, {63'b0, e.dz});
`endif
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    reset_n = 1'b0; start = 1'b0; op = 3'b000; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
`ifdef MDU_DIV0_FLAG_EN
    check("rst_dz", {63'b0, dz}, 64'd0);
`endif
    reset_n = 1'b1;

    push_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_commit(-1);
    push_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_commit(-1);
    // Signed divide with an ignored start arriving mid-operation.
    push_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_commit(2);
    push_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit(-1);

    // Back-to-back moves into HI then LO.
    @(negedge clk);
    op = OP_MTHI; A = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    check("mthi_hi", {32'b0, hi}, 64'h1234_5678);
    check("mthi_busy", {63'b0, busy}, 64'd0);
    op = OP_MTLO; A = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = 3'b000;
    check("mtlo_lo", {32'b0, lo}, 64'h9ABC_DEF0);
    check("mtlo_hi", {32'b0, hi}, 64'h1234_5678);
    check("mtlo_busy", {63'b0, busy}, 64'd0);
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;

    // Reset during an in-flight divide aborts it.
    drive(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("abort_busy_pre", {63'b0, busy}, 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (12) @(negedge clk);
    check("abort_late_busy", {63'b0, busy}, 64'd0);
    check("abort_late_hi", {32'b0, hi}, 64'd0);
    check("abort_late_lo", {32'b0, lo}, 64'd0);

    // Give HI/LO known nonzero contents, then divide by zero.
    push_op(OP_MULTU, 32'd3, 32'd4);
    wait_commit(-1);
    push_op(OP_DIVU, 32'd5, 32'd0);
    wait_commit(-1);
`ifdef MDU_DIV0_FLAG_EN
    @(negedge clk);
    check("divzero_pulse_end", {63'b0, dz}, 64'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      ro = 3'(1 + $urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'(int'($urandom_range(0, 15)) - 8);
      push_op(ro, ra, rb);
      wait_commit(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
